// File: rtl/key_pkg.sv
// Shared types, default constants and width helper for the key event front end.
package key_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    localparam int KEY_TICK_CYCLES    = 20000;
    localparam int KEY_STABLE_SAMPLES = 20;

    // Bit width able to index n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_filter.sv
// One key: two-flop synchroniser followed by a strobe-paced debounce filter.
module key_filter
    import key_pkg::*;
#(
    parameter int STABLE_SAMPLES = KEY_STABLE_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic strobe,
    output logic key_state,
    output logic rise
);

    localparam int              CNT_W    = clog2_min1(STABLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] agree_cnt;
    logic             flip;

    // The level flips on the strobe that completes the run of disagreeing samples.
    assign flip = strobe && (sync_p1 != key_state) && (agree_cnt == CNT_LAST);
    assign rise = flip && sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            agree_cnt <= '0;
            key_state <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability settling
            sync_p0 <= key;
            sync_p1 <= sync_p0;
            // filter stage: any agreeing sample restarts the run
            if (strobe) begin
                if (sync_p1 == key_state) begin
                    agree_cnt <= '0;
                end else if (flip) begin
                    agree_cnt <= '0;
                    key_state <= sync_p1;
                end else begin
                    agree_cnt <= agree_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/key_event_arb.sv
// Debounces NKEYS push-buttons on a shared sample tick and serialises press
// events onto a valid/ready port through a round-robin arbiter.
module key_event_arb
    import key_pkg::*;
#(
    parameter int NKEYS          = 4,
    parameter int TICK_CYCLES    = KEY_TICK_CYCLES,
    parameter int STABLE_SAMPLES = KEY_STABLE_SAMPLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NKEYS-1:0]              key,
    output logic [NKEYS-1:0]              key_state,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [clog2_min1(NKEYS)-1:0]  evt_id,
    output logic [NKEYS-1:0]              ovf,
    input  logic                          ovf_clr
);

    localparam int               ID_W      = clog2_min1(NKEYS);
    localparam int               TICK_W    = clog2_min1(TICK_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NKEYS - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              strobe;
    logic [NKEYS-1:0]  rise;

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [ID_W-1:0]   evt_id_nx;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_nx;
    logic [ID_W-1:0]   pick_id;
    logic [NKEYS-1:0]  pending;
    logic [NKEYS-1:0]  pending_nx;
    logic [NKEYS-1:0]  ovf_nx;
    logic              hs;

    assign strobe = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || strobe) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        key_filter #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_filter (
            .clk      (clk),
            .rst      (rst),
            .key      (key[k]),
            .strobe   (strobe),
            .key_state(key_state[k]),
            .rise     (rise[k])
        );
    end

    // Descending scan so the lowest offset from rr_ptr is the one left standing.
    always_comb begin
        int idx;
        idx     = 0;
        pick_id = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NKEYS;
            if (pending[idx]) begin
                pick_id = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        evt_id_nx = evt_id;
        rr_nx     = rr_ptr;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nx  = OFFER;
                    evt_id_nx = pick_id;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    hs       = 1'b1;
                    state_nx = IDLE;
                    rr_nx    = (evt_id == ID_LAST) ? '0 : evt_id + ID_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A new press beats the handshake clear; only an uncleared pending flag overflows.
    always_comb begin
        logic clr_k;
        clr_k      = 1'b0;
        pending_nx = pending;
        ovf_nx     = ovf_clr ? '0 : ovf;
        for (int k = 0; k < NKEYS; k++) begin
            clr_k = hs && (evt_id == ID_W'(k));
            if (rise[k]) begin
                pending_nx[k] = 1'b1;
                if (pending[k] && !clr_k) begin
                    ovf_nx[k] = 1'b1;
                end
            end else if (clr_k) begin
                pending_nx[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            evt_id  <= '0;
            rr_ptr  <= '0;
            pending <= '0;
            ovf     <= '0;
        end else begin
            state   <= state_nx;
            evt_id  <= evt_id_nx;
            rr_ptr  <= rr_nx;
            pending <= pending_nx;
            ovf     <= ovf_nx;
        end
    end

    assign evt_valid = (state == OFFER);

endmodule
